// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding IF/ID; owns the PC and a req/ack instruction-memory port.
// Latency: if_valid rises the edge after imem_ack; zero-wait memory sustains one instruction per cycle.
// Backpressure: pc_write=0 parks an acked word in a hold buffer (imem_req low); redirects squash in-flight fetches.
// Optional feature macro: IF_PERF_CNT_EN adds fetch_count/stall_count output ports.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_plus_out,
  output logic [31:0] inst_out,
  output logic        if_valid,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
`endif
  output logic        if_flush
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_q;
  logic [31:0] hold_inst_q;
  logic [31:0] hold_pcp_q;
  logic [31:0] inst_q;
  logic [31:0] pcp_q;
  logic        req_q;
  logic        valid_q;

  logic [31:0] pc_inc;
  logic [31:0] tgt;
  logic        ack;

  assign pc_inc = pc_q + 32'd4;
  assign tgt    = branch_target & ~32'h3;
  // An ack is only meaningful while a request is actually on the bus.
  assign ack    = imem_ack & req_q;

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc_plus_out = pcp_q;
  assign inst_out    = inst_q;
  assign if_valid    = valid_q;
  assign if_flush    = branch_taken;

  // Fetch FSM: PC ownership, squash/hold handling and registered IF/ID outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC & ~32'h3;
      pend_q      <= 32'h0;
      hold_inst_q <= 32'h0;
      hold_pcp_q  <= 32'h0;
      inst_q      <= 32'h0;
      pcp_q       <= 32'h0;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      // Request stays up everywhere except while parked in HOLD.
      req_q   <= 1'b1;
      valid_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (ack) begin
            if (branch_taken) begin
              pc_q <= tgt;
            end else if (pc_write) begin
              inst_q  <= imem_rdata;
              pcp_q   <= pc_inc;
              valid_q <= 1'b1;
              pc_q    <= pc_inc;
            end else begin
              hold_inst_q <= imem_rdata;
              hold_pcp_q  <= pc_inc;
              req_q       <= 1'b0;
              state_q     <= S_HOLD;
            end
          end else if (branch_taken) begin
            // The outstanding fetch must still be drained before redirecting.
            pend_q  <= tgt;
            state_q <= S_DISCARD;
          end
        end
        S_HOLD: begin
          if (branch_taken) begin
            pc_q    <= tgt;
            state_q <= S_FETCH;
          end else if (pc_write) begin
            inst_q  <= hold_inst_q;
            pcp_q   <= hold_pcp_q;
            valid_q <= 1'b1;
            pc_q    <= hold_pcp_q;
            state_q <= S_FETCH;
          end else begin
            req_q <= 1'b0;
          end
        end
        S_DISCARD: begin
          if (ack) begin
            pc_q    <= branch_taken ? tgt : pend_q;
            state_q <= S_FETCH;
          end else if (branch_taken) begin
            pend_q <= tgt;
          end
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Free-running counters of delivered instructions and cycles spent parked in HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (valid_q) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (state_q == S_HOLD) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized traffic
// against an architectural model (next expected PC, latest-redirect-wins).
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        pc_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_plus_out;
  logic [31:0] inst_out;
  logic        if_valid;
  logic        if_flush;

  // Second instance with a wrapping reset PC and a zero-wait memory.
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_pcp;
  logic [31:0] w_inst;
  logic        w_valid;
  logic        w_flush;

  int n_chk  = 0;
  int n_fail = 0;
  int n_deliv = 0;
  int mem_lat;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic wait_valid(input int maxc, output bit got);
    got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk);
      #1;
      if (if_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  if_fetch_unit u_dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_plus_out(pc_plus_out),
    .inst_out(inst_out), .if_valid(if_valid), .if_flush(if_flush)
  );

  assign w_rdata = memf(w_addr);

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .pc_write(1'b1), .branch_taken(1'b0),
    .branch_target(32'h0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_req), .imem_rdata(w_rdata), .pc_plus_out(w_pcp),
    .inst_out(w_inst), .if_valid(w_valid), .if_flush(w_flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: responds on the falling edge so an ack can share the cycle with req.
  initial begin : mem
    bit          outst;
    int          wait_c;
    int          cur_lat;
    logic [31:0] oaddr;
    outst = 1'b0; wait_c = 0; cur_lat = 0; oaddr = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (!rst) begin
        outst  = 1'b0;
        wait_c = 0;
      end else begin
        if (outst) begin
          chk("req_held_until_ack", 32'(imem_req), 32'd1);
          chk("addr_stable_until_ack", imem_addr, oaddr);
        end
        if (imem_req) begin
          if (!outst) begin
            outst   = 1'b1;
            oaddr   = imem_addr;
            wait_c  = 0;
            cur_lat = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
          end
          if (wait_c >= cur_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = memf(imem_addr);
            outst      = 1'b0;
          end else begin
            wait_c++;
          end
        end
      end
    end
  end

  // Architectural model: the next delivered instruction is the one at next_pc;
  // any redirect replaces next_pc (latest wins) and suppresses delivery on that edge.
  initial begin : cmp
    logic [31:0] next_pc;
    logic [31:0] last_pcp;
    logic [31:0] last_inst;
    logic [31:0] tgt_s;
    logic        br;
    logic        pw;
    next_pc = 32'h0; last_pcp = 32'h0; last_inst = 32'h0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        next_pc   = 32'h0;
        last_pcp  = 32'h0;
        last_inst = 32'h0;
      end else begin
        br    = branch_taken;
        pw    = pc_write;
        tgt_s = branch_target;
        chk("flush_follows_branch", 32'(if_flush), 32'(br));
        #1;
        if (br) begin
          chk("no_valid_on_redirect", 32'(if_valid), 32'd0);
          next_pc = tgt_s & ~32'h3;
        end else if (if_valid) begin
          chk("valid_needs_pc_write", 32'(pw), 32'd1);
          chk("model_pc_plus", pc_plus_out, next_pc + 32'd4);
          chk("model_inst", inst_out, memf(next_pc));
          next_pc = next_pc + 32'd4;
          n_deliv++;
        end else begin
          chk("pc_plus_hold", pc_plus_out, last_pcp);
          chk("inst_hold", inst_out, last_inst);
        end
        chk("addr_aligned", imem_addr & 32'h3, 32'h0);
        last_pcp  = pc_plus_out;
        last_inst = inst_out;
      end
    end
  end

  initial begin : main
    bit got;
    rst = 1'b0; pc_write = 1'b1; branch_taken = 1'b0; branch_target = 32'h0; mem_lat = 0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc_plus", pc_plus_out, 32'h0);
    chk("rst_inst", inst_out, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
    chk("rst_wrap_req", 32'(w_req), 32'd0);
    rst = 1'b1;

    // Zero-wait streaming, wrap instance, then a two-cycle stall on the ack of 0x8.
    @(posedge clk); #1;
    chk("e1_req", 32'(imem_req), 32'd1);
    chk("e1_valid", 32'(if_valid), 32'd0);
    chk("e1_addr", imem_addr, 32'h0);
    chk("e1_wrap_req", 32'(w_req), 32'd1);
    @(posedge clk); #1;
    chk("e2_valid", 32'(if_valid), 32'd1);
    chk("e2_pc_plus", pc_plus_out, 32'h4);
    chk("e2_inst", inst_out, memf(32'h0));
    chk("wrap_valid", 32'(w_valid), 32'd1);
    chk("wrap_pc_plus", w_pcp, 32'h0);
    chk("wrap_inst", w_inst, memf(32'hFFFF_FFFC));
    chk("wrap_next_addr", w_addr, 32'h0);
    @(posedge clk); #1;
    chk("e3_pc_plus", pc_plus_out, 32'h8);
    chk("e3_addr", imem_addr, 32'h8);
    @(negedge clk); pc_write = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("hold_req_low", 32'(imem_req), 32'd0);
      chk("hold_no_valid", 32'(if_valid), 32'd0);
    end
    @(negedge clk); pc_write = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", 32'(if_valid), 32'd1);
    chk("release_pc_plus", pc_plus_out, 32'hC);
    chk("release_inst", inst_out, memf(32'h8));
    chk("release_addr", imem_addr, 32'hC);

    // Redirect to 0x100 while the fetch of 0x10 is still outstanding.
    @(posedge clk); #1;
    chk("pre_branch_addr", imem_addr, 32'h10);
    mem_lat = 2;
    @(negedge clk); branch_taken = 1'b1; branch_target = 32'h100;
    #1 chk("flush_high", 32'(if_flush), 32'd1);
    @(posedge clk); #1;
    chk("discard_no_valid", 32'(if_valid), 32'd0);
    chk("discard_addr_old", imem_addr, 32'h10);
    @(negedge clk); branch_taken = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (imem_addr != 32'h10) begin
        got = 1'b1;
        break;
      end
    end
    chk("redirect_seen_in_time", 32'(got), 32'd1);
    chk("redirect_addr", imem_addr, 32'h100);
    chk("redirect_no_valid", 32'(if_valid), 32'd0);
    wait_valid(10, got);
    chk("redirect_valid_in_time", 32'(got), 32'd1);
    chk("redirect_pc_plus", pc_plus_out, 32'h104);
    chk("redirect_inst", inst_out, memf(32'h100));

    // Multi-cycle memory latency from a fresh reset.
    @(negedge clk); rst = 1'b0; mem_lat = 2;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("lat_req", 32'(imem_req), 32'd1);
      chk("lat_addr", imem_addr, 32'h0);
      chk("lat_no_valid", 32'(if_valid), 32'd0);
    end
    @(posedge clk); #1;
    chk("lat_valid", 32'(if_valid), 32'd1);
    chk("lat_pc_plus", pc_plus_out, 32'h4);
    chk("lat_next_addr", imem_addr, 32'h4);

    // Reset dropped mid-fetch, between clock edges.
    #2 rst = 1'b0;
    #1;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_valid", 32'(if_valid), 32'd0);
    chk("midrst_pc_plus", pc_plus_out, 32'h0);
    chk("midrst_inst", inst_out, 32'h0);
    chk("midrst_addr", imem_addr, 32'h0);
    mem_lat = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("refetch_addr", imem_addr, 32'h0);
    chk("refetch_req", 32'(imem_req), 32'd1);
    wait_valid(5, got);
    chk("refetch_valid_in_time", 32'(got), 32'd1);
    chk("refetch_pc_plus", pc_plus_out, 32'h4);
    chk("refetch_inst", inst_out, memf(32'h0));

    // Randomized traffic: random latency, stalls and redirects (some near the top of memory).
    mem_lat = -1;
    n_deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      pc_write     = ($urandom_range(0, 3) != 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0)
        branch_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else
        branch_target = $urandom;
    end
    @(negedge clk); branch_taken = 1'b0; pc_write = 1'b1;
    repeat (10) @(negedge clk);
    chk("random_deliveries", 32'(n_deliv > 200), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
